// File: rtl/i2s_rx_ctrl.sv
// I2S receive sequencer: frame alignment, MSB-first deserialization, framing checks and stereo pair handoff.
// Optional error counter output err_cnt is enabled by defining I2S_RX_ERRCNT_EN.
module i2s_rx_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sck_transition,
   input  logic             sd,
   input  logic             ws,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr,
`ifdef I2S_RX_ERRCNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic             locked
);

   typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

   state_t           state_q, state_d;
   logic             ws_prev_q, ws_prev_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] out_left_q, out_left_d;
   logic [WIDTH-1:0] out_right_q, out_right_d;
   logic             out_valid_q, out_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
`ifdef I2S_RX_ERRCNT_EN
   logic [7:0]       err_cnt_q, err_cnt_d;
`endif

   logic [WIDTH-1:0] word;
   logic [CNT_W-1:0] cnt_inc;
   logic             boundary, err, pair_done, drop;

   always_comb begin
      state_d     = state_q;
      ws_prev_d   = ws_prev_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      left_hold_d = left_hold_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      out_valid_d = out_valid_q;
      err         = 1'b0;
      pair_done   = 1'b0;
      drop        = 1'b0;
      // The word including the bit arriving this rise; at a boundary that bit is the LSB.
      word        = {shift_q[WIDTH-2:0], sd};
      cnt_inc     = bit_cnt_q + CNT_W'(1);
      boundary    = sck_transition && (ws != ws_prev_q);

      if (sck_transition) begin
         shift_d   = word;
         ws_prev_d = ws;
      end

      if (!en) begin
         state_d   = HUNT;
         bit_cnt_d = '0;
      end else if (sck_transition) begin
         case (state_q)
            HUNT: begin
               if (boundary && !ws) begin
                  bit_cnt_d = '0;
                  state_d   = LEFT;
               end
            end
            LEFT, RIGHT: begin
               if (!boundary) begin
                  if (cnt_inc == CNT_W'(WIDTH)) err = 1'b1;
                  else bit_cnt_d = cnt_inc;
               end else if (cnt_inc == CNT_W'(WIDTH) && (ws == (state_q == LEFT))) begin
                  bit_cnt_d = '0;
                  if (state_q == LEFT) begin
                     left_hold_d = word;
                     state_d     = RIGHT;
                  end else begin
                     pair_done = 1'b1;
                     state_d   = LEFT;
                  end
               end else begin
                  err = 1'b1;
               end
               if (err) begin
                  state_d   = HUNT;
                  bit_cnt_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      // A new pair may replace one being consumed this very cycle.
      if (pair_done) begin
         if (!out_valid_q || out_ready) begin
            out_left_d  = left_hold_q;
            out_right_d = word;
            out_valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      frame_err_d = err;
      overrun_d   = drop | (overrun_q & ~clr);
`ifdef I2S_RX_ERRCNT_EN
      err_cnt_d = err_cnt_q;
      if (err || drop) err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      else if (clr) err_cnt_d = 8'h00;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         ws_prev_q   <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         left_hold_q <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef I2S_RX_ERRCNT_EN
         err_cnt_q   <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         ws_prev_q   <= ws_prev_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         left_hold_q <= left_hold_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef I2S_RX_ERRCNT_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign out_left  = out_left_q;
   assign out_right = out_right_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign locked    = (state_q != HUNT);
`ifdef I2S_RX_ERRCNT_EN
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: word-level I2S stream generator with a frame-level expectation model.
module tb_i2s_rx_ctrl;
   localparam int W = 16;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sck_transition = 1'b0;
   logic sd = 1'b0, ws = 1'b0, out_ready = 1'b0, clr = 1'b0;
   logic [W-1:0] out_left, out_right;
   logic out_valid, frame_err, overrun, locked;
`ifdef I2S_RX_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int checks = 0, failures = 0;
   int gap = 80;
   int ferr_seen = 0, exp_ferr = 0;
   bit rnd_ready = 1'b0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   i2s_rx_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sck_transition(sck_transition),
      .sd(sd), .ws(ws), .out_left(out_left), .out_right(out_right),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
      .overrun(overrun), .clr(clr),
`ifdef I2S_RX_ERRCNT_EN
      .err_cnt(err_cnt),
`endif
      .locked(locked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock; a handshake seen just before the edge is scored against the expected pair queue.
   task automatic tick();
      logic hs;
      logic [2*W-1:0] pr;
      hs = out_valid && out_ready;
      pr = {out_left, out_right};
      @(posedge clk);
      #1;
      if (hs) begin
         chk("pair_was_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("pair", pr, exp_q.pop_front());
      end
      if (frame_err) ferr_seen++;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic rise(input logic b, input logic w);
      repeat (gap - 1) tick();
      sd = b;
      ws = w;
      sck_transition = 1'b1;
      tick();
      sck_transition = 1'b0;
   endtask

   // Bits lo..hi-1 of an n-bit word on channel c; ws already shows the next channel on the last bit.
   task automatic send_bits(input logic c, input logic [W-1:0] d, input int n, input logic nc,
                            input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         logic b;
         b = (i < W) ? d[W-1-i] : 1'($urandom_range(0, 1));
         rise(b, (i == n - 1) ? nc : c);
      end
   endtask

   task automatic send_word(input logic c, input logic [W-1:0] d, input int n, input logic nc);
      send_bits(c, d, n, nc, 0, n);
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
      send_word(1'b0, l, W, 1'b1);
      send_word(1'b1, r, W, 1'b0);
   endtask

   task automatic drain(input string tag);
      repeat (4) tick();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bit lost;
      @(posedge clk);
      #1;
      chk("rst_out_left", 32'(out_left), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      en = 1'b1;
      out_ready = 1'b1;
      tick();

      // Lock and first pairs at 40-clk half sck
      send_bits(1'b1, 16'h0F0F, W, 1'b0, 0, W - 1);
      chk("locked_before_boundary", 32'(locked), 32'd0);
      send_bits(1'b1, 16'h0F0F, W, 1'b0, W - 1, W);
      chk("locked_after_boundary", 32'(locked), 32'd1);
      exp_q.push_back({16'hAAAA, 16'hFFFF});
      exp_q.push_back({16'h1478, 16'hA3B9});
      send_frame(16'hAAAA, 16'hFFFF);
      send_frame(16'h1478, 16'hA3B9);
      drain("first_pairs_drained");
      chk("no_frame_err_first", 32'(ferr_seen), 32'(exp_ferr));

      // Backpressure and overrun
      gap = 6;
      out_ready = 1'b0;
      send_frame(16'hCDD7, 16'hBABA);
      chk("bp_valid_latency", 32'(out_valid), 32'd1);
      chk("bp_pair", {out_left, out_right}, 32'hCDD7BABA);
      chk("bp_no_overrun_yet", 32'(overrun), 32'd0);
      send_frame(16'h4444, 16'hAAAA);
      chk("bp_overrun", 32'(overrun), 32'd1);
      chk("bp_pair_held", {out_left, out_right}, 32'hCDD7BABA);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("bp_overrun_clr", 32'(overrun), 32'd0);
      exp_q.push_back({16'hCDD7, 16'hBABA});
      out_ready = 1'b1;
      drain("bp_drained");

      // Short left word: framing error, relock on the next 1->0 boundary
      send_word(1'b0, 16'h1234, 15, 1'b1);
      exp_ferr++;
      chk("short_ferr_pulse", 32'(frame_err), 32'd1);
      chk("short_unlocked", 32'(locked), 32'd0);
      tick();
      chk("short_ferr_one_clk", 32'(frame_err), 32'd0);
      send_word(1'b1, 16'h5678, W, 1'b0);
      chk("short_relock", 32'(locked), 32'd1);
      exp_q.push_back({16'h7398, 16'hFFDD});
      send_frame(16'h7398, 16'hFFDD);
      drain("short_drained");
      chk("short_ferr_count", 32'(ferr_seen), 32'(exp_ferr));

      // Overlong right word
      send_word(1'b0, 16'h5A5A, W, 1'b1);
      send_bits(1'b1, 16'hC3C3, 17, 1'b0, 0, 16);
      exp_ferr++;
      chk("ovf_ferr_pulse", 32'(frame_err), 32'd1);
      chk("ovf_hunt", 32'(locked), 32'd0);
      send_bits(1'b1, 16'hC3C3, 17, 1'b0, 16, 17);
      chk("ovf_relock", 32'(locked), 32'd1);
      exp_q.push_back({16'h1357, 16'h2468});
      send_frame(16'h1357, 16'h2468);
      drain("ovf_drained");
      chk("ovf_ferr_count", 32'(ferr_seen), 32'(exp_ferr));

      // Enable dropped for one clk during bit 7 of a left word
      send_bits(1'b0, 16'h1111, W, 1'b1, 0, 7);
      en = 1'b0;
      tick();
      en = 1'b1;
      chk("en_drop_hunt", 32'(locked), 32'd0);
      send_bits(1'b0, 16'h1111, W, 1'b1, 7, W);
      send_word(1'b1, 16'h2222, W, 1'b0);
      exp_q.push_back({16'h0001, 16'hFFFF});
      send_frame(16'h0001, 16'hFFFF);
      drain("en_drained");
      chk("en_no_ferr", 32'(ferr_seen), 32'(exp_ferr));

      // Reset in the middle of a right word
      send_word(1'b0, 16'h5555, W, 1'b1);
      send_bits(1'b1, 16'h6666, W, 1'b0, 0, 8);
      rst_n = 1'b0;
      #2;
      chk("midrst_out_left", 32'(out_left), 32'd0);
      chk("midrst_out_right", 32'(out_right), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      send_bits(1'b1, 16'h6666, W, 1'b0, 8, W);
      chk("midrst_relock", 32'(locked), 32'd1);
      exp_q.push_back({16'h0001, 16'hFFFF});
      send_frame(16'h0001, 16'hFFFF);
      drain("midrst_drained");

      // Random frames with occasional malformed words and random backpressure
      gap = 3;
      rnd_ready = 1'b1;
      lost = 1'b0;
      for (int f = 0; f < 40; f++) begin
         int kind;
         logic [W-1:0] l, r;
         kind = $urandom_range(0, 9);
         l = W'($urandom);
         r = W'($urandom);
         if (lost) lost = 1'b0;
         else if (kind == 5 || kind == 6 || kind == 7) exp_ferr++;
         else if (kind == 8) begin
            exp_ferr++;
            lost = 1'b1;
         end else exp_q.push_back({l, r});
         case (kind)
            5: begin send_word(1'b0, l, $urandom_range(1, W - 1), 1'b1); send_word(1'b1, r, W, 1'b0); end
            6: begin send_word(1'b0, l, $urandom_range(W + 1, W + 4), 1'b1); send_word(1'b1, r, W, 1'b0); end
            7: begin send_word(1'b0, l, W, 1'b1); send_word(1'b1, r, $urandom_range(W + 1, W + 4), 1'b0); end
            8: begin send_word(1'b0, l, W, 1'b1); send_word(1'b1, r, $urandom_range(1, W - 1), 1'b0); end
            default: send_frame(l, r);
         endcase
      end
      if (lost) send_frame(16'h0000, 16'h0000);
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      drain("rand_drained");
      chk("rand_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
      chk("rand_no_overrun", 32'(overrun), 32'd0);

`ifdef I2S_RX_ERRCNT_EN
      gap = 2;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("errcnt_clr0", 32'(err_cnt), 32'd0);
      for (int k = 0; k < 3; k++) begin
         send_word(1'b0, 16'hF000, 5, 1'b1);
         send_word(1'b1, 16'h0F00, 5, 1'b0);
      end
      out_ready = 1'b0;
      send_frame(16'h1A2B, 16'h3C4D);
      send_frame(16'h5E6F, 16'h7081);
      chk("errcnt_four", 32'(err_cnt), 32'd4);
      exp_q.push_back({16'h1A2B, 16'h3C4D});
      out_ready = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("errcnt_clr", 32'(err_cnt), 32'd0);
      drain("errcnt_drained");
      for (int k = 0; k < 300; k++) begin
         send_word(1'b0, 16'hF000, 1, 1'b1);
         send_word(1'b1, 16'h0F00, 1, 1'b0);
      end
      chk("errcnt_sat", 32'(err_cnt), 32'hFF);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("errcnt_sat_clr", 32'(err_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
